// File: rtl/udp_key_extractor.sv
// udp_key_extractor
// Passive tap on a 64-bit AXI4-Stream receive path. For every IPv4/UDP frame it
// builds the flow key {src_ip, dst_ip, dst_port, 16'h0} and a DNS op flag, and
// pulses out_valid for one cycle. Fields are captured by absolute byte offset.
// Optional 802.1Q support is enabled by defining KEY_EXT_VLAN_EN; without it a
// tagged frame fails the ethertype check.
module udp_key_extractor #(
    parameter int          KEY_SIZE    = 96,
    parameter int          TDATA_WIDTH = 64,
    parameter logic [15:0] DNS_PORT    = 16'd53
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [TDATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [KEY_SIZE-1:0]        out_key,
    output logic [3:0]                 out_flag,
    output logic                       out_valid
);

    localparam logic [15:0] ETH_IPV4 = 16'h0800;
    localparam logic [15:0] ETH_VLAN = 16'h8100;
    localparam logic [7:0]  VER_IHL  = 8'h45;
    localparam logic [7:0]  PROTO_UDP = 8'd17;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_PARSE = 2'd2,
        ST_SKIP  = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [2:0]  beat_cnt_r;
    logic        beat_s;
    logic        capture_s;
    logic        emit_s;
    logic        fail_s;
    logic        done_s;
    logic        vlan_s;
    logic [5:0]  s_off_s;
    logic [5:0]  last_off_s;

    logic [15:0] etype_r,  etype_s;
    logic [7:0]  verihl_r, verihl_s;
    logic [15:0] frag_r,   frag_s;
    logic [7:0]  proto_r,  proto_s;
    logic [31:0] src_ip_r, src_ip_s;
    logic [31:0] dst_ip_r, dst_ip_s;
    logic [15:0] sport_r,  sport_s;
    logic [15:0] dport_r,  dport_s;
`ifdef KEY_EXT_VLAN_EN
    logic [15:0] inner_r,  inner_s;
`endif

    // Byte at frame offset 'off' if it rides on the current beat, else the held value.
    function automatic logic [7:0] pick_byte(input logic [63:0] data, input logic [2:0] beat,
                                             input logic [5:0] off, input logic [7:0] held);
        if (off[5:3] == beat) begin
            return data[{off[2:0], 3'b000} +: 8];
        end else begin
            return held;
        end
    endfunction

    // True when frame offset 'off' is carried by the current beat.
    function automatic logic on_beat(input logic [2:0] beat, input logic [5:0] off);
        return (off[5:3] == beat);
    endfunction

    assign beat_s = s_axis_tvalid & s_axis_tready;

    // Merge the current beat's bytes into each header field (S-relative offsets follow the tag).
    always_comb begin
        etype_s = {pick_byte(s_axis_tdata, beat_cnt_r, 6'd12, etype_r[15:8]),
                   pick_byte(s_axis_tdata, beat_cnt_r, 6'd13, etype_r[7:0])};
`ifdef KEY_EXT_VLAN_EN
        inner_s = {pick_byte(s_axis_tdata, beat_cnt_r, 6'd16, inner_r[15:8]),
                   pick_byte(s_axis_tdata, beat_cnt_r, 6'd17, inner_r[7:0])};
        vlan_s  = (etype_s == ETH_VLAN);
`else
        vlan_s  = 1'b0;
`endif
        s_off_s    = vlan_s ? 6'd4 : 6'd0;
        last_off_s = 6'd37 + s_off_s;
        verihl_s = pick_byte(s_axis_tdata, beat_cnt_r, 6'd14 + s_off_s, verihl_r);
        frag_s   = {pick_byte(s_axis_tdata, beat_cnt_r, 6'd20 + s_off_s, frag_r[15:8]),
                    pick_byte(s_axis_tdata, beat_cnt_r, 6'd21 + s_off_s, frag_r[7:0])};
        proto_s  = pick_byte(s_axis_tdata, beat_cnt_r, 6'd23 + s_off_s, proto_r);
        src_ip_s = {pick_byte(s_axis_tdata, beat_cnt_r, 6'd26 + s_off_s, src_ip_r[31:24]),
                    pick_byte(s_axis_tdata, beat_cnt_r, 6'd27 + s_off_s, src_ip_r[23:16]),
                    pick_byte(s_axis_tdata, beat_cnt_r, 6'd28 + s_off_s, src_ip_r[15:8]),
                    pick_byte(s_axis_tdata, beat_cnt_r, 6'd29 + s_off_s, src_ip_r[7:0])};
        dst_ip_s = {pick_byte(s_axis_tdata, beat_cnt_r, 6'd30 + s_off_s, dst_ip_r[31:24]),
                    pick_byte(s_axis_tdata, beat_cnt_r, 6'd31 + s_off_s, dst_ip_r[23:16]),
                    pick_byte(s_axis_tdata, beat_cnt_r, 6'd32 + s_off_s, dst_ip_r[15:8]),
                    pick_byte(s_axis_tdata, beat_cnt_r, 6'd33 + s_off_s, dst_ip_r[7:0])};
        sport_s  = {pick_byte(s_axis_tdata, beat_cnt_r, 6'd34 + s_off_s, sport_r[15:8]),
                    pick_byte(s_axis_tdata, beat_cnt_r, 6'd35 + s_off_s, sport_r[7:0])};
        dport_s  = {pick_byte(s_axis_tdata, beat_cnt_r, 6'd36 + s_off_s, dport_r[15:8]),
                    pick_byte(s_axis_tdata, beat_cnt_r, 6'd37 + s_off_s, dport_r[7:0])};
    end

    // Each criterion is judged on the beat that completes its field; the key is done
    // when offset 37+S arrives (and, on the tlast beat, its keep lane is set).
    always_comb begin
        fail_s = (on_beat(beat_cnt_r, 6'd13) && (etype_s != ETH_IPV4) && !vlan_s)
`ifdef KEY_EXT_VLAN_EN
               || (vlan_s && on_beat(beat_cnt_r, 6'd17) && (inner_s != ETH_IPV4))
`endif
               || (on_beat(beat_cnt_r, 6'd14 + s_off_s) && (verihl_s != VER_IHL))
               || (on_beat(beat_cnt_r, 6'd21 + s_off_s) && ((frag_s & 16'h3FFF) != 16'h0000))
               || (on_beat(beat_cnt_r, 6'd23 + s_off_s) && (proto_s != PROTO_UDP));
        done_s = on_beat(beat_cnt_r, last_off_s)
               && (!s_axis_tlast || s_axis_tkeep[last_off_s[2:0]]);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_SYNC;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; tlast with a handshake always closes the frame.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_SYNC: begin
                if (!s_axis_tvalid) begin
                    state_s = ST_IDLE;
                end else if (beat_s) begin
                    state_s = s_axis_tlast ? ST_IDLE : ST_SKIP;
                end else begin
                    state_s = ST_SYNC;
                end
            end
            ST_IDLE: begin
                if (beat_s && !s_axis_tlast) begin
                    state_s = ST_PARSE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PARSE: begin
                if (!beat_s) begin
                    state_s = ST_PARSE;
                end else if (s_axis_tlast) begin
                    state_s = ST_IDLE;
                end else if (fail_s || done_s) begin
                    state_s = ST_SKIP;
                end else begin
                    state_s = ST_PARSE;
                end
            end
            ST_SKIP: begin
                if (beat_s && s_axis_tlast) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SKIP;
                end
            end
            default: state_s = ST_SYNC;
        endcase
    end

    // Output decode: capture on parse beats, emit when the key completes cleanly.
    always_comb begin
        capture_s = 1'b0;
        emit_s    = 1'b0;
        case (state_r)
            ST_PARSE: begin
                capture_s = beat_s;
                emit_s    = beat_s && done_s && !fail_s;
            end
            default: begin
                capture_s = 1'b0;
                emit_s    = 1'b0;
            end
        endcase
    end

    // Beat counter: index of the current beat within the frame, saturating at 7.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_r <= 3'd0;
        end else if (beat_s) begin
            if (s_axis_tlast) begin
                beat_cnt_r <= 3'd0;
            end else if (beat_cnt_r != 3'd7) begin
                beat_cnt_r <= beat_cnt_r + 3'd1;
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Header field registers, updated with the merged values on parse beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            etype_r  <= 16'h0000;
            verihl_r <= 8'h00;
            frag_r   <= 16'h0000;
            proto_r  <= 8'h00;
            src_ip_r <= 32'h0000_0000;
            dst_ip_r <= 32'h0000_0000;
            sport_r  <= 16'h0000;
            dport_r  <= 16'h0000;
`ifdef KEY_EXT_VLAN_EN
            inner_r  <= 16'h0000;
`endif
        end else if (capture_s) begin
            etype_r  <= etype_s;
            verihl_r <= verihl_s;
            frag_r   <= frag_s;
            proto_r  <= proto_s;
            src_ip_r <= src_ip_s;
            dst_ip_r <= dst_ip_s;
            sport_r  <= sport_s;
            dport_r  <= dport_s;
`ifdef KEY_EXT_VLAN_EN
            inner_r  <= inner_s;
`endif
        end else begin
            etype_r  <= etype_r;
        end
    end

    // Registered outputs: key/flag held until the next emit, valid is a single pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_key   <= '0;
            out_flag  <= 4'b0000;
        end else begin
            out_valid <= emit_s;
            if (emit_s) begin
                out_key  <= {src_ip_s, dst_ip_s, dport_s, 16'h0000};
                out_flag <= {2'b00, (sport_s == DNS_PORT), (dport_s == DNS_PORT)};
            end else begin
                out_key  <= out_key;
            end
        end
    end

endmodule

// File: tb/tb_udp_key_extractor.sv
// Self-checking bench for udp_key_extractor: frames are built as byte arrays, a
// frame-level model decides whether a key is due and on which beat, and one
// compare process checks the outputs on every cycle.
module tb_udp_key_extractor;

    localparam int K_UDP = 0, K_TCP = 1, K_IHL6 = 2, K_MF = 3, K_FOFF = 4,
                   K_V6 = 5, K_VLAN = 6, K_GARB = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid, tready, tlast;
    logic [95:0] out_key;
    logic [3:0]  out_flag;
    logic        out_valid;

    always #5 clk = ~clk;

    udp_key_extractor dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (tdata),
        .s_axis_tkeep  (tkeep),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .s_axis_tlast  (tlast),
        .out_key       (out_key),
        .out_flag      (out_flag),
        .out_valid     (out_valid)
    );

    typedef struct {
        int         cyc;
        logic [95:0] key;
        logic [3:0]  flag;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        rst_q    = 1'b1;
    exp_t        expq[$];
    logic [95:0] held_key  = 96'h0;
    logic [3:0]  held_flag = 4'h0;
    int          pulse_cnt = 0;
    int          last_pulse_cyc = 0;
    logic [95:0] last_key  = 96'h0;
    logic [3:0]  last_flag = 4'h0;
    logic [7:0]  fb [0:127];
    int          flen = 0;
    bit          tog = 1'b1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Single compare point, half a cycle after each active edge.
    always @(negedge clk) begin
        logic v_exp;
        exp_t e;
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missed_pulse: no out_valid, expected at cycle %0d", expq[0].cyc);
            void'(expq.pop_front());
        end
        if (rst_q) begin
            held_key  = 96'h0;
            held_flag = 4'h0;
            check("reset_valid", {127'h0, out_valid}, 128'h0);
            check("reset_key", {32'h0, out_key}, 128'h0);
            check("reset_flag", {124'h0, out_flag}, 128'h0);
        end else begin
            v_exp = (expq.size() > 0 && expq[0].cyc == cyc);
            check("out_valid", {127'h0, out_valid}, {127'h0, v_exp});
            if (v_exp) begin
                e = expq.pop_front();
                held_key  = e.key;
                held_flag = e.flag;
            end
            check("out_key", {32'h0, out_key}, {32'h0, held_key});
            check("out_flag", {124'h0, out_flag}, {124'h0, held_flag});
            if (out_valid) begin
                pulse_cnt++;
                last_pulse_cyc = cyc;
                last_key  = out_key;
                last_flag = out_flag;
            end
        end
    end

    // Frame-level reference: decides from the bytes whether a key is due, on which beat.
    function automatic void model(input int len, output bit emit, output int ebeat,
                                  output logic [95:0] key, output logic [3:0] flag);
        int s;
        logic [15:0] et, frag;
        emit = 1'b0; ebeat = 0; key = 96'h0; flag = 4'h0; s = 0;
        if (len < 14) return;
        et = {fb[12], fb[13]};
`ifdef KEY_EXT_VLAN_EN
        if (et == 16'h8100) begin
            s  = 4;
            et = {fb[16], fb[17]};
        end
`endif
        if (len < 38 + s) return;
        frag = {fb[20+s], fb[21+s]};
        if (et != 16'h0800 || fb[14+s] != 8'h45 || (frag & 16'h3FFF) != 16'h0 || fb[23+s] != 8'd17)
            return;
        emit  = 1'b1;
        ebeat = (37 + s) / 8;
        key   = {fb[26+s], fb[27+s], fb[28+s], fb[29+s], fb[30+s], fb[31+s], fb[32+s], fb[33+s],
                 fb[36+s], fb[37+s], 16'h0000};
        flag  = {2'b00, ({fb[34+s], fb[35+s]} == 16'd53), ({fb[36+s], fb[37+s]} == 16'd53)};
    endfunction

    task automatic build(input int kind, input int len, input logic [31:0] sip, input logic [31:0] dip,
                         input logic [15:0] sp, input logic [15:0] dp);
        int s;
        for (int i = 0; i < 128; i++) fb[i] = 8'($urandom);
        flen = len;
        s = (kind == K_VLAN) ? 4 : 0;
        if (kind == K_VLAN) begin
            fb[12] = 8'h81; fb[13] = 8'h00; fb[16] = 8'h08; fb[17] = 8'h00;
        end else begin
            fb[12] = 8'h08; fb[13] = 8'h00;
        end
        fb[14+s] = 8'h45;
        fb[20+s] = 8'($urandom) & 8'h40;
        fb[21+s] = 8'h00;
        fb[23+s] = 8'd17;
        {fb[26+s], fb[27+s], fb[28+s], fb[29+s]} = sip;
        {fb[30+s], fb[31+s], fb[32+s], fb[33+s]} = dip;
        {fb[34+s], fb[35+s]} = sp;
        {fb[36+s], fb[37+s]} = dp;
        case (kind)
            K_TCP:  fb[23] = 8'd6;
            K_IHL6: fb[14] = 8'h46;
            K_MF:   fb[20] = 8'h20;
            K_FOFF: fb[21] = 8'h01;
            K_V6:   begin fb[12] = 8'h86; fb[13] = 8'hDD; end
            K_GARB: for (int i = 12; i < 24; i++) fb[i] = 8'($urandom);
            default: ;
        endcase
    endtask

    // mode 0: always ready; 1: tready toggles; 2: random tvalid/tready.
    task automatic send(input int mode, input int rst_from, input int rst_upto, input bit no_emit,
                        output int emit_hs_cyc, output int first_hs_cyc);
        bit emit;
        int eb, nb, tries;
        logic [95:0] k;
        logic [3:0] f;
        exp_t e;
        model(flen, emit, eb, k, f);
        if (no_emit) emit = 1'b0;
        emit_hs_cyc = -1;
        first_hs_cyc = -1;
        nb = (flen + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 8; i++) begin
                tdata[8*i +: 8] = (8*b + i < flen) ? fb[8*b + i] : 8'($urandom);
                tkeep[i] = (b < nb - 1) || (8*b + i < flen);
            end
            tlast = (b == nb - 1);
            if (rst_from >= 0 && b >= rst_from && b <= rst_upto) rst = 1'b1;
            tries = 0;
            do begin
                case (mode)
                    0: begin tvalid = 1'b1; tready = 1'b1; end
                    1: begin tvalid = 1'b1; tready = tog; tog = ~tog; end
                    default: begin
                        tvalid = ($urandom_range(0, 9) < 8);
                        tready = ($urandom_range(0, 9) < 7);
                    end
                endcase
                if (tries > 40) begin tvalid = 1'b1; tready = 1'b1; end
                @(posedge clk);
                #1;
                tries++;
            end while (!(tvalid && tready));
            if (b == 0) first_hs_cyc = cyc;
            if (b == rst_upto) rst = 1'b0;
            if (emit && b == eb) begin
                e.cyc = cyc; e.key = k; e.flag = f;
                expq.push_back(e);
                emit_hs_cyc = cyc;
            end
        end
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0;
        tlast  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int eh, fh, pc, kind, len;
        rst = 1'b1; tvalid = 1'b0; tready = 1'b0; tlast = 1'b0; tdata = 64'h0; tkeep = 8'h0;
        repeat (4) @(posedge clk);
        #1;

        // Reset released while a frame is already streaming: no key for it.
        pc = pulse_cnt;
        build(K_UDP, 64, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd53);
        send(0, 0, 2, 1'b1, eh, fh);
        idle(2);
        check("midframe_release_pulses", 128'(pulse_cnt - pc), 128'd0);

        // Reference frame, continuous stream.
        pc = pulse_cnt;
        build(K_UDP, 64, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd53);
        send(0, -1, -1, 1'b0, eh, fh);
        idle(3);
        check("A_pulses", 128'(pulse_cnt - pc), 128'd1);
        check("A_key", {32'h0, last_key}, {32'h0, 96'h0A000001_0A000002_0035_0000});
        check("A_flag", {124'h0, last_flag}, {124'h0, 4'b0001});
        check("A_latency", 128'(last_pulse_cyc - fh), 128'd4);

        // Same frame, tready toggling.
        pc = pulse_cnt;
        tog = 1'b1;
        build(K_UDP, 64, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd53);
        send(1, -1, -1, 1'b0, eh, fh);
        idle(3);
        check("B_pulses", 128'(pulse_cnt - pc), 128'd1);
        check("B_key", {32'h0, last_key}, {32'h0, 96'h0A000001_0A000002_0035_0000});
        check("B_flag", {124'h0, last_flag}, {124'h0, 4'b0001});
        check("B_after_5th_hs", 128'(last_pulse_cyc), 128'(eh));

        // Rejected frames back to back, then a DNS-source frame.
        pc = pulse_cnt;
        build(K_TCP, 64, 32'hC0A80001, 32'hC0A80002, 16'd53, 16'd80);   send(0, -1, -1, 1'b0, eh, fh);
        build(K_IHL6, 64, 32'hC0A80001, 32'hC0A80002, 16'd53, 16'd80);  send(0, -1, -1, 1'b0, eh, fh);
        build(K_MF, 64, 32'hC0A80001, 32'hC0A80002, 16'd53, 16'd80);    send(0, -1, -1, 1'b0, eh, fh);
        build(K_V6, 64, 32'hC0A80001, 32'hC0A80002, 16'd53, 16'd80);    send(0, -1, -1, 1'b0, eh, fh);
        build(K_UDP, 64, 32'h01020304, 32'h05060708, 16'd53, 16'd4000); send(0, -1, -1, 1'b0, eh, fh);
        idle(3);
        check("neg_then_udp_pulses", 128'(pulse_cnt - pc), 128'd1);
        check("sport53_flag", {124'h0, last_flag}, {124'h0, 4'b0010});
        check("sport53_key", {32'h0, last_key}, {32'h0, 96'h01020304_05060708_0FA0_0000});

        // 36-byte frame ends before dst_port, next frame parses.
        pc = pulse_cnt;
        build(K_UDP, 36, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd53); send(0, -1, -1, 1'b0, eh, fh);
        build(K_UDP, 64, 32'h0A0A0A0A, 32'h0B0B0B0B, 16'd7, 16'd9);     send(0, -1, -1, 1'b0, eh, fh);
        idle(3);
        check("short_then_good_pulses", 128'(pulse_cnt - pc), 128'd1);

        // Reset on the emit beat drops the pending key.
        pc = pulse_cnt;
        build(K_UDP, 64, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd53); send(0, 4, 4, 1'b1, eh, fh);
        idle(2);
        check("reset_drop_pulses", 128'(pulse_cnt - pc), 128'd0);
        build(K_UDP, 60, 32'h11111111, 32'h22222222, 16'd53, 16'd53);   send(0, -1, -1, 1'b0, eh, fh);
        idle(3);
        check("after_reset_pulses", 128'(pulse_cnt - pc), 128'd1);
        check("after_reset_flag", {124'h0, last_flag}, {124'h0, 4'b0011});

        // Tagged frame.
        pc = pulse_cnt;
        build(K_VLAN, 70, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd53); send(0, -1, -1, 1'b0, eh, fh);
        idle(3);
`ifdef KEY_EXT_VLAN_EN
        check("vlan_pulses", 128'(pulse_cnt - pc), 128'd1);
        check("vlan_latency", 128'(last_pulse_cyc - fh), 128'd5);
        check("vlan_key", {32'h0, last_key}, {32'h0, 96'h0A000001_0A000002_0035_0000});
`else
        check("vlan_pulses", 128'(pulse_cnt - pc), 128'd0);
`endif

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 9);
            if (kind > K_GARB) kind = K_UDP;
            if (kind == K_GARB)      len = $urandom_range(1, 128);
            else if (kind == K_VLAN) len = $urandom_range(30, 128);
            else                     len = $urandom_range(30, 128);
            build(kind, len, $urandom, $urandom,
                  ($urandom_range(0, 3) == 0) ? 16'd53 : 16'($urandom),
                  ($urandom_range(0, 3) == 0) ? 16'd53 : 16'($urandom));
            send(($urandom_range(0, 2) == 0) ? 0 : 2, -1, -1, 1'b0, eh, fh);
            idle($urandom_range(0, 2));
        end
        idle(5);
        check("queue_drained", 128'(expq.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
